// File: rtl/controller.sv
// Four-state Moore mode controller: classifies requests x/y into a registered
// 2-bit mode code, with an optional minimum-dwell hold between mode changes.
module controller #(
    parameter int MIN_DWELL = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       x,
    input  logic       y,
    output logic [1:0] out
);

    localparam int CW = $clog2(MIN_DWELL) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MODE_A = 2'b01,
        MODE_B = 2'b10,
        MODE_C = 2'b11
    } state_t;

    state_t          state_q, state_d, table_next;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dwell_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        table_next = state_q;
        case (state_q)
            IDLE: begin
                case ({x, y})
                    2'b10:   table_next = MODE_A;
                    2'b01:   table_next = MODE_B;
                    2'b11:   table_next = MODE_C;
                    default: table_next = IDLE;
                endcase
            end
            MODE_A: begin
                // y escalates straight to MODE_C while in MODE_A
                case ({x, y})
                    2'b10:   table_next = MODE_A;
                    2'b00:   table_next = IDLE;
                    default: table_next = MODE_C;
                endcase
            end
            MODE_B: begin
                case ({x, y})
                    2'b01:   table_next = MODE_B;
                    2'b00:   table_next = IDLE;
                    default: table_next = MODE_C;
                endcase
            end
            default: begin
                case ({x, y})
                    2'b10:   table_next = MODE_A;
                    2'b01:   table_next = MODE_B;
                    2'b00:   table_next = IDLE;
                    default: table_next = MODE_C;
                endcase
            end
        endcase

        dwell_done = (cnt_q == CNT_MAX);
        state_d    = dwell_done ? table_next : state_q;

        // Counter restarts on each mode change, otherwise saturates at CNT_MAX
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (!dwell_done) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        out = state_q;
    end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: one instance with no dwell, one with MIN_DWELL=4.
module tb_controller;

    logic       clock;
    logic       reset;
    logic       x, y;
    logic       x4, y4;
    logic [1:0] out;
    logic [1:0] out4;
    int         errors;
    int         checks;

    controller #(.MIN_DWELL(1)) dut (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .y     (y),
        .out   (out)
    );

    controller #(.MIN_DWELL(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .x     (x4),
        .y     (y4),
        .out   (out4)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        x = 1'b0; y = 1'b0;
        x4 = 1'b0; y4 = 1'b0;

        #5;
        chk("reset_early", out, 2'b00);
        #50;
        chk("reset_mid", out, 2'b00);
        chk("reset_mid4", out4, 2'b00);
        #45;
        reset = 1'b0;
        tick();
        chk("post_reset", out, 2'b00);
        tick();
        chk("idle_hold", out, 2'b00);

        // IDLE -> A -> IDLE
        x = 1'b1; y = 1'b0; tick(); chk("idle_to_a", out, 2'b01);
        x = 1'b0; y = 1'b0; tick(); chk("a_to_idle", out, 2'b00);

        // IDLE -> B -> C -> A -> C -> B
        x = 1'b0; y = 1'b1; tick(); chk("idle_to_b", out, 2'b10);
        x = 1'b1; y = 1'b1; tick(); chk("b_to_c", out, 2'b11);
        x = 1'b1; y = 1'b0; tick(); chk("c_to_a", out, 2'b01);
        x = 1'b1; y = 1'b1; tick(); chk("a_to_c", out, 2'b11);
        x = 1'b0; y = 1'b1; tick(); chk("c_to_b", out, 2'b10);
        tick();                     chk("b_stay", out, 2'b10);

        // Escalation: B with 10 goes to C, A with 01 goes to C
        x = 1'b1; y = 1'b0; tick(); chk("b_esc", out, 2'b11);
        x = 1'b1; y = 1'b0; tick(); chk("c_to_a2", out, 2'b01);
        x = 1'b0; y = 1'b1; tick(); chk("a_esc", out, 2'b11);
        x = 1'b1; y = 1'b1; tick(); chk("c_stay", out, 2'b11);

        // Dwell of 4: dut4 has been idle long enough for its counter to saturate
        x4 = 1'b1; y4 = 1'b0; tick(); chk("dw_enter_a", out4, 2'b01);
        x4 = 1'b0; y4 = 1'b0;
        tick(); chk("dw_hold1", out4, 2'b01);
        tick(); chk("dw_hold2", out4, 2'b01);
        tick(); chk("dw_hold3", out4, 2'b01);
        tick(); chk("dw_release", out4, 2'b00);

        // Freshly entered IDLE must also dwell before moving to B
        x4 = 1'b0; y4 = 1'b1;
        tick(); chk("dw_idle_hold1", out4, 2'b00);
        tick(); chk("dw_idle_hold2", out4, 2'b00);
        tick(); chk("dw_idle_hold3", out4, 2'b00);
        tick(); chk("dw_idle_to_b", out4, 2'b10);
        // Stay code for several edges lets the counter saturate
        tick(); tick(); tick(); tick();
        chk("dw_b_stay", out4, 2'b10);

        // Asynchronous reset between edges while main dut sits in MODE_C
        chk("pre_async_c", out, 2'b11);
        #5;
        reset = 1'b1;
        #1;
        chk("async_rst", out, 2'b00);
        chk("async_rst4", out4, 2'b00);
        x = 1'b1; y = 1'b0;
        x4 = 1'b1; y4 = 1'b0;
        @(negedge clock);
        chk("rst_held", out, 2'b00);
        reset = 1'b0;

        // Main dut moves at once; dut4 counter restarted from 0 so it waits 3 edges
        tick(); chk("after_rst_a", out, 2'b01);
        chk("dw_clr_hold1", out4, 2'b00);
        tick(); chk("dw_clr_hold2", out4, 2'b00);
        tick(); chk("dw_clr_hold3", out4, 2'b00);
        tick(); chk("dw_clr_to_a", out4, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Four-state Moore controller that classifies the two request inputs x and y into a 2-bit registered mode code on out.
- Sits between request-generating logic and downstream blocks that consume a stable mode.
- An optional minimum-dwell counter keeps each mode held for a programmable number of cycles before it may change.

Parameters:
- MIN_DWELL, default 1: minimum number of clock cycles a state is held before a transition is allowed. Legal values are integers 1 or greater; 1 means no hold.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- x      input  1  request input x; synchronous to clock.
- y      input  1  request input y; synchronous to clock.
- out    output 2  current mode code; registered and equal to the state encoding.

Behaviour:
- State encoding, with out equal to the state:
  - IDLE = 2'b00
  - MODE_A = 2'b01
  - MODE_B = 2'b10
  - MODE_C = 2'b11
- Reset:
  - Asserting reset immediately forces state to IDLE and out to 2'b00, independent of clock.
  - Reset also clears the dwell counter to 0.
  - While reset is high, nothing else changes.
  - On the first rising edge after reset deasserts, the machine evaluates normally.
- Next-state function, evaluated on each rising edge with inputs {x,y}:
  - IDLE:
    - 00 -> IDLE
    - 10 -> MODE_A
    - 01 -> MODE_B
    - 11 -> MODE_C
  - MODE_A:
    - 10 -> MODE_A
    - 00 -> IDLE
    - 01 or 11 -> MODE_C (y is sticky-escalating)
  - MODE_B:
    - 01 -> MODE_B
    - 00 -> IDLE
    - 10 or 11 -> MODE_C (x is sticky-escalating)
  - MODE_C:
    - 11 -> MODE_C
    - 10 -> MODE_A
    - 01 -> MODE_B
    - 00 -> IDLE
- Timing:
  - Moore machine: out depends only on state.
  - Latency from an input change to the out change is one rising edge, provided the dwell has expired.
  - No combinational path from x or y to out.
- Dwell counter:
  - Width is clog2(MIN_DWELL)+1.
  - Cleared to 0 on every state change.
  - Otherwise increments each edge, saturating at MIN_DWELL-1.
  - A transition is permitted only on an edge where counter == MIN_DWELL-1. Otherwise the state holds, and the counter keeps incrementing or stays saturated.
  - With MIN_DWELL=1 the counter is constantly 0 and transitions are always permitted.
- Boundary conditions:
  - Inputs that return to the current state's "stay" code while dwell is pending cause no transition and no glitch on out.
  - Simultaneous change of x and y is resolved by the table above; there is no priority beyond it.
  - Reset asserted mid-dwell or mid-transition wins unconditionally.
  - X or Z on the inputs is not handled; the bench drives known values only.

Test Plan:
- Reset held 100 ns (clock period 20 ns) with x=0, y=0 -> out=00 throughout reset and after release; still 00 while inputs stay 00.
- From IDLE drive x=1,y=0 -> out=01 on the next rising edge. Then drive x=0,y=0 -> out=00 one edge later.
- From IDLE drive x=0,y=1 -> out=10. Then drive x=1,y=1 -> out=11. Then x=1,y=0 -> out=01. Then x=1,y=1 -> out=11. Then x=0,y=1 -> out=10. Each change appears one edge after the input change.
- In MODE_A drive x=0,y=1 -> out=11, not 10, confirming escalation. In MODE_B drive x=1,y=0 -> out=11.
- MIN_DWELL=4: from IDLE apply 10 for 1 cycle, then 00 -> out=01 after the first edge, then held for 3 more edges before returning to 00.
- Assert reset asynchronously between clock edges while out=11 -> out=00 before the next edge; the counter is cleared.
